// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    RESTORE,
    SIGN,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/result bundle between ALU and divider
interface div_sequencer_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational non-restoring divide iteration
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] a_shift;

  // Shift {A,Q} left by one; the sign of A before the shift picks add or subtract.
  always_comb begin
    a_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
    a_out   = a_in[WIDTH] ? (a_shift + m_in) : (a_shift - m_in);
    q_out   = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle signed divide controller returning {quotient, remainder}
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clock,
  input  logic          clear,
  div_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt;
  logic             sq;
  logic             sr;
  logic             zero_div;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Operand magnitudes at accept and signed results at SIGN; min-int magnitude fits unsigned.
  always_comb begin
    dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    quot    = sq ? -q_reg : q_reg;
    rem     = sr ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
  end

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_reg),
    .q_in  (q_reg),
    .m_in  (m_reg),
    .a_out (a_next),
    .q_out (q_next)
  );

  // Control FSM with registered outputs; DONE spends one cycle arming the done pulse.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      a_reg        <= '0;
      m_reg        <= '0;
      q_reg        <= '0;
      cnt          <= '0;
      sq           <= 1'b0;
      sr           <= 1'b0;
      zero_div     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy     <= 1'b1;
            bus.div_zero <= 1'b0;
            a_reg        <= '0;
            cnt          <= CNT_W'(WIDTH - 1);
            sq           <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sr           <= bus.dividend[WIDTH-1];
            if (bus.divisor == '0) begin
              // Keep the raw dividend; it is returned unchanged as the remainder.
              zero_div <= 1'b1;
              q_reg    <= bus.dividend;
              m_reg    <= '0;
              state    <= DONE;
            end else begin
              zero_div <= 1'b0;
              q_reg    <= dvd_mag;
              m_reg    <= {1'b0, dvs_mag};
              state    <= ITER;
            end
          end
        end
        ITER: begin
          a_reg <= a_next;
          q_reg <= q_next;
          if (cnt == '0) begin
            state <= RESTORE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESTORE: begin
          if (a_reg[WIDTH]) begin
            a_reg <= a_reg + m_reg;
          end
          state <= SIGN;
        end
        SIGN: begin
          bus.result <= {quot, rem};
          state      <= DONE;
        end
        DONE: begin
          if (!bus.done) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            if (zero_div) begin
              bus.result   <= {{WIDTH{1'b1}}, q_reg};
              bus.div_zero <= 1'b1;
            end
          end else begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;
  import div_pkg::*;

  localparam int W = 32;
  localparam int NONZERO_LAT = W + 3;
  localparam int N_RANDOM = 1200;

  logic clock;
  logic clear;
  int   n_vec;
  int   n_bad;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating signed division from plain arithmetic, with the two special cases.
  function automatic logic [63:0] ref_div(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    if (b == 0) return {DIV_ZERO_QUOT, a};
    if (a == 32'sh8000_0000 && b == -32'sd1) return {32'h8000_0000, 32'h0};
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  // Issue one operation from a negedge; returns at the negedge after the done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [63:0] res, output logic dz, output int lat,
                        output int bcnt, output logic done_after);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat  = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clock);
      if (bus.done) break;
      if (bus.busy) bcnt++;
      @(posedge clock);
      lat++;
    end
    res = bus.result;
    dz  = bus.div_zero;
    @(posedge clock);
    @(negedge clock);
    done_after = bus.done;
  endtask

  initial begin
    logic [63:0] res;
    logic        dz;
    logic        done_after;
    int          lat;
    int          bcnt;
    int          k;
    logic        saw_done;
    logic [W-1:0] a;
    logic [W-1:0] b;

    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    tbl[1]  = '{-32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0};
    tbl[2]  = '{32'd7,          -32'sd2,        -32'sd3,        32'd1,          1'b0};
    tbl[3]  = '{-32'sd7,        -32'sd2,        32'd3,          -32'sd1,        1'b0};
    tbl[4]  = '{32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123,        1'b1};
    tbl[5]  = '{32'd10,         32'd5,          32'd2,          32'd0,          1'b0};
    tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[7]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
    tbl[8]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[9]  = '{-32'sd5,        32'h8000_0000,  32'd0,          -32'sd5,        1'b0};
    tbl[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
    tbl[11] = '{32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};

    clear        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #3;
    check("reset_busy",     64'(bus.busy),     64'd0);
    check("reset_done",     64'(bus.done),     64'd0);
    check("reset_result",   bus.result,        64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].dvd, tbl[i].dvs, res, dz, lat, bcnt, done_after);
      check($sformatf("tbl%0d_result", i), res, {tbl[i].exp_q, tbl[i].exp_r});
      check($sformatf("tbl%0d_div_zero", i), 64'(dz), 64'(tbl[i].exp_dz));
      check($sformatf("tbl%0d_latency", i), 64'(lat), tbl[i].exp_dz ? 64'd1 : 64'(NONZERO_LAT));
      check($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), tbl[i].exp_dz ? 64'd1 : 64'(NONZERO_LAT));
      check($sformatf("tbl%0d_done_pulse", i), 64'(done_after), 64'd0);
    end

    // 20/3 with an ignored start at edge 10, then a start held from done onward.
    bus.dividend = 32'd20;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clock);
    #1 bus.start = 1'b0;
    k = 10;
    while (k < 200) begin
      @(negedge clock);
      if (bus.done) break;
      @(posedge clock);
      k++;
    end
    check("ignored_start_latency", 64'(k), 64'(NONZERO_LAT));
    check("ignored_start_result", bus.result, {32'd6, 32'd2});
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd7;
    k = 0;
    while (k < 200) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check("held_start_gap", 64'(k), 64'(NONZERO_LAT + 2));
    check("held_start_result", bus.result, {32'd7, 32'd1});
    @(posedge clock);
    @(negedge clock);

    // Asynchronous clear in the middle of 100/7.
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    check("clear_busy",   64'(bus.busy), 64'd0);
    check("clear_done",   64'(bus.done), 64'd0);
    check("clear_result", bus.result,    64'd0);
    @(negedge clock);
    clear = 1'b0;
    saw_done = 1'b0;
    repeat (45) begin
      @(negedge clock);
      if (bus.done) saw_done = 1'b1;
    end
    check("clear_no_done", 64'(saw_done), 64'd0);
    run_op(32'd9, 32'd4, res, dz, lat, bcnt, done_after);
    check("after_clear_result", res, {32'd2, 32'd1});

    // Randomized pairs against the arithmetic reference.
    for (int i = 0; i < N_RANDOM; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = 32'h8000_0000;
        2: a = 32'h8000_0000;
        3: b = W'($urandom_range(0, 15)) - 32'd8;
        4: a = W'($urandom_range(0, 300)) - 32'd150;
        default: ;
      endcase
      run_op(a, b, res, dz, lat, bcnt, done_after);
      if (res !== ref_div(a, b) || dz !== (b == '0) || lat != ((b == '0) ? 1 : NONZERO_LAT)) begin
        $display("FAIL rand%0d %h/%h: got res=%h dz=%0b lat=%0d expected res=%h dz=%0b",
                 i, a, b, res, dz, lat, ref_div(a, b), (b == '0));
        n_bad++;
      end
      n_vec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
